// File: rtl/xts_pkg.sv
// rtl/xts_pkg.sv - shared types and width helpers for the XTS length tracker
package xts_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BULK  = 2'd1,
    STEAL = 2'd2,
    DONE  = 2'd3
  } xts_state_e;

  localparam int XTS_BLOCK_BYTES = 16;

  // Width of the byte offset inside one cipher block
  function automatic int xts_off_w(input int block_bytes);
    return $clog2(block_bytes);
  endfunction

  // Width of a whole-block count for a byte length of len_w bits
  function automatic int xts_cnt_w(input int len_w, input int block_bytes);
    return len_w - $clog2(block_bytes);
  endfunction

endpackage

// File: rtl/xts_blk_counter.sv
// rtl/xts_blk_counter.sv - loadable block down-counter with terminal-at-one flag
module xts_blk_counter #(
  parameter int W = 124
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_one
);

  // Clear wins over load, load wins over decrement; zero never wraps
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign at_one = (count == W'(1));

endmodule

// File: rtl/xts_len_tracker.sv
// rtl/xts_len_tracker.sv - XTS message length tracker with ciphertext-stealing sequencing
module xts_len_tracker
  import xts_pkg::*;
#(
  parameter  int LEN_W       = 128,
  parameter  int BLOCK_BYTES = XTS_BLOCK_BYTES,
  localparam int OFF_W       = xts_off_w(BLOCK_BYTES),
  localparam int CNT_W       = xts_cnt_w(LEN_W, BLOCK_BYTES)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             len_load,
  input  logic [LEN_W-1:0] len_in,
  input  logic             blk_done,
  input  logic             abort,
  output logic             busy,
  output logic [CNT_W-1:0] blocks_left,
  output logic [CNT_W-1:0] blk_idx,
  output logic [OFF_W-1:0] tail_bytes,
  output logic             last_full,
  output logic             penult,
  output logic             steal_active,
  output logic             done,
  output logic             len_err
);

  xts_state_e       state, state_nxt;
  logic [CNT_W-1:0] len_full;
  logic [OFF_W-1:0] len_tail;
  logic             load_try;
  logic             load_ok;
  logic             load_bad;
  logic             blk_dec;
  logic             blk_adv;
  logic             cnt_at_one;

  assign len_full = len_in[LEN_W-1:OFF_W];
  assign len_tail = len_in[OFF_W-1:0];

  // abort drops a coincident load; loads are only honoured in IDLE
  assign load_try = (state == IDLE) && len_load && !abort;
  assign load_ok  = load_try && (len_full != '0);
  assign load_bad = load_try && (len_full == '0);
  assign blk_dec  = (state == BULK) && blk_done && !abort;
  assign blk_adv  = ((state == BULK) || (state == STEAL)) && blk_done && !abort;

  xts_blk_counter #(
    .W (CNT_W)
  ) u_blk_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (abort),
    .load     (load_ok),
    .load_val (len_full),
    .dec      (blk_dec),
    .count    (blocks_left),
    .at_one   (cnt_at_one)
  );

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Tweak index, tail length and the short-length error pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      blk_idx    <= '0;
      tail_bytes <= '0;
      len_err    <= 1'b0;
    end else begin
      len_err <= load_bad;
      if (abort) begin
        blk_idx    <= '0;
        tail_bytes <= '0;
      end else if (load_ok) begin
        blk_idx    <= '0;
        tail_bytes <= len_tail;
      end else if (blk_adv) begin
        blk_idx <= blk_idx + CNT_W'(1);
      end
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    steal_active = 1'b0;
    done         = 1'b0;
    last_full    = 1'b0;
    penult       = 1'b0;
    case (state)
      IDLE: begin
        if (load_ok) state_nxt = BULK;
      end
      BULK: begin
        busy      = 1'b1;
        last_full = cnt_at_one && (tail_bytes == '0);
        penult    = cnt_at_one && (tail_bytes != '0);
        if (blk_done && cnt_at_one) begin
          state_nxt = (tail_bytes != '0) ? STEAL : DONE;
        end
      end
      STEAL: begin
        busy         = 1'b1;
        steal_active = 1'b1;
        if (blk_done) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

endmodule

// File: tb/tb_xts_len_tracker.sv
// tb/tb_xts_len_tracker.sv - scoreboard bench for xts_len_tracker
module tb_xts_len_tracker;

  localparam int LEN_W = 128;
  localparam int BB    = 16;
  localparam int OFF_W = 4;
  localparam int CNT_W = 124;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             len_load;
  logic [LEN_W-1:0] len_in;
  logic             blk_done;
  logic             abort;
  logic             busy;
  logic [CNT_W-1:0] blocks_left;
  logic [CNT_W-1:0] blk_idx;
  logic [OFF_W-1:0] tail_bytes;
  logic             last_full;
  logic             penult;
  logic             steal_active;
  logic             done;
  logic             len_err;

  xts_len_tracker #(.LEN_W(LEN_W), .BLOCK_BYTES(BB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .len_load     (len_load),
    .len_in       (len_in),
    .blk_done     (blk_done),
    .abort        (abort),
    .busy         (busy),
    .blocks_left  (blocks_left),
    .blk_idx      (blk_idx),
    .tail_bytes   (tail_bytes),
    .last_full    (last_full),
    .penult       (penult),
    .steal_active (steal_active),
    .done         (done),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             busy;
    logic [CNT_W-1:0] blocks_left;
    logic [CNT_W-1:0] blk_idx;
    logic [OFF_W-1:0] tail_bytes;
    logic             last_full;
    logic             penult;
    logic             steal_active;
    logic             done;
    logic             len_err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a message is "full blocks + optional stolen block"
  logic [CNT_W-1:0] m_full;
  logic [OFF_W-1:0] m_tail;
  logic [CNT_W:0]   m_cons;
  logic             m_done;
  logic             m_err;

  function automatic logic [CNT_W:0] m_total();
    return {1'b0, m_full} + ((m_tail != '0) ? 1 : 0);
  endfunction

  function automatic logic m_busy();
    return (m_full != '0) && (m_cons < m_total());
  endfunction

  function automatic exp_t m_expect();
    exp_t e;
    e.busy         = m_busy();
    e.blocks_left  = ({1'b0, m_full} > m_cons) ? (m_full - m_cons[CNT_W-1:0]) : '0;
    e.blk_idx      = m_cons[CNT_W-1:0];
    e.tail_bytes   = m_tail;
    e.last_full    = e.busy && ({1'b0, m_full} == m_cons + 1) && (m_tail == '0);
    e.penult       = e.busy && ({1'b0, m_full} == m_cons + 1) && (m_tail != '0);
    e.steal_active = e.busy && (m_tail != '0) && (m_cons == {1'b0, m_full});
    e.done         = m_done;
    e.len_err      = m_err;
    return e;
  endfunction

  task automatic m_reset();
    m_full = '0; m_tail = '0; m_cons = '0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic m_update(input logic ld, input logic [LEN_W-1:0] len, input logic bd, input logic ab);
    logic was_busy;
    logic was_done;
    was_busy = m_busy();
    was_done = m_done;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (ab) begin
      m_full = '0; m_tail = '0; m_cons = '0;
    end else if (was_busy) begin
      if (bd) begin
        m_cons = m_cons + 1;
        if (m_cons == m_total()) m_done = 1'b1;
      end
    end else if (!was_done && ld) begin
      if (len < BB) begin
        m_err = 1'b1;
      end else begin
        m_full = len / BB;
        m_tail = len % BB;
        m_cons = '0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [LEN_W-1:0] act, input logic [LEN_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard
  task automatic step(input logic ld, input logic [LEN_W-1:0] len, input logic bd, input logic ab);
    @(negedge clk);
    len_load = ld;
    len_in   = len;
    blk_done = bd;
    abort    = ab;
    m_update(ld, len, bd, ab);
    exp_q.push_back(m_expect());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Issue n blk_done pulses with random gaps; spurious loads only while busy
  task automatic blocks(input int n, input bit spurious);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if (spurious && m_busy()) step(1'b1, LEN_W'($urandom_range(0, 200)), 1'b0, 1'b0);
        else                      step(1'b0, '0, 1'b0, 1'b0);
      end
      step(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},         busy,         0);
    chk({tag, ".blocks_left"},  blocks_left,  0);
    chk({tag, ".blk_idx"},      blk_idx,      0);
    chk({tag, ".tail_bytes"},   tail_bytes,   0);
    chk({tag, ".last_full"},    last_full,    0);
    chk({tag, ".penult"},       penult,       0);
    chk({tag, ".steal_active"}, steal_active, 0);
    chk({tag, ".done"},         done,         0);
    chk({tag, ".len_err"},      len_err,      0);
  endtask

  // Monitor: pop one expectation per clock and compare every output
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy",         busy,         e.busy);
      chk("blocks_left",  blocks_left,  e.blocks_left);
      chk("blk_idx",      blk_idx,      e.blk_idx);
      chk("tail_bytes",   tail_bytes,   e.tail_bytes);
      chk("last_full",    last_full,    e.last_full);
      chk("penult",       penult,       e.penult);
      chk("steal_active", steal_active, e.steal_active);
      chk("done",         done,         e.done);
      chk("len_err",      len_err,      e.len_err);
    end
  end

  initial begin
    logic [LEN_W-1:0] all_ones;
    all_ones = '1;
    n_rst    = 1'b0;
    len_load = 1'b0;
    len_in   = '0;
    blk_done = 1'b0;
    abort    = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    n_rst = 1'b1;
    idle(2);

    // 64 bytes: four full blocks, no stealing
    step(1'b1, 128'd64, 1'b0, 1'b0);
    blocks(4, 1'b0);
    idle(2);

    // 37 bytes: two full blocks plus a 5-byte tail
    step(1'b1, 128'd37, 1'b0, 1'b0);
    blocks(3, 1'b0);
    idle(2);

    // 15 bytes rejected, then a single-block message
    step(1'b1, 128'd15, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 128'd16, 1'b0, 1'b0);
    blocks(1, 1'b0);
    idle(2);

    // 160 bytes with ignored loads, then abort together with a blk_done
    step(1'b1, 128'd160, 1'b0, 1'b0);
    step(1'b1, 128'd48, 1'b0, 1'b0);
    blocks(3, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(3);

    // Asynchronous reset in the middle of BULK
    step(1'b1, 128'd48, 1'b0, 1'b0);
    blocks(1, 1'b0);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1 chk_all_zero("async_reset");
    m_reset();
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    step(1'b1, 128'd33, 1'b0, 1'b0);
    blocks(3, 1'b0);
    idle(2);

    // Maximum length: huge block count, no false terminal flags
    step(1'b1, all_ones, 1'b0, 1'b0);
    blocks(3, 1'b1);
    idle(1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // Random traffic, including loads in DONE and coincident abort/load
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 6) == 0, LEN_W'($urandom_range(0, 100)),
           ($urandom % 3) == 0, ($urandom % 50) == 0);
    end
    idle(3);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xts_len_tracker.md
Name: xts_len_tracker

Overview:
Parametrised XTS message-length tracker sitting between the host size-register interface and the XTS datapath sequencer.
- Loads a byte length once per message, then counts whole cipher blocks down as the datapath consumes them.
- Exposes the block index used for tweak advancement.
- Detects the ciphertext-stealing case (non-zero tail) and sequences the final full and partial blocks.
- Rejects lengths shorter than one block.

Parameters:
LEN_W, 128, width of the message length field in bytes.
BLOCK_BYTES, 16, cipher block size in bytes; must be a power of 2, at least 2.
OFF_W, derived localparam $clog2(BLOCK_BYTES), width of the tail byte count.
CNT_W, derived localparam LEN_W-OFF_W, width of the block counters.

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
len_load  in  1  load strobe for len_in; honoured only in IDLE
len_in  in  LEN_W  message length in bytes
blk_done  in  1  one-cycle pulse: datapath finished one block
abort  in  1  synchronous abort of the current message
busy  out  1  high in BULK or STEAL
blocks_left  out  CNT_W  full blocks not yet consumed
blk_idx  out  CNT_W  blocks consumed so far in this message (tweak index j)
tail_bytes  out  OFF_W  length of the partial final block; 0 means no stealing
last_full  out  1  current block is the final block, and tail_bytes==0
penult  out  1  current block is the last full block, and tail_bytes!=0 (its output is stolen)
steal_active  out  1  high in STEAL: current block is the merged tail/stolen block
done  out  1  one-cycle pulse at message completion
len_err  out  1  one-cycle pulse when the loaded length is below BLOCK_BYTES

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-message discards everything.
- States: IDLE, BULK, STEAL, DONE.
- IDLE, on len_load:
  - full = len_in[LEN_W-1:OFF_W], tail = len_in[OFF_W-1:0].
  - If full==0: len_err=1 for the next cycle only, remain in IDLE, counters unchanged.
  - Otherwise, next cycle: blocks_left=full, blk_idx=0, tail_bytes=tail, state BULK, busy=1.
- BULK, on each blk_done: blocks_left-1, blk_idx+1.
  - If blocks_left==1 at the pulse and tail==0: go to DONE.
  - If blocks_left==1 at the pulse and tail!=0: go to STEAL.
- STEAL: blocks_left=0; the first blk_done goes to DONE, with blk_idx+1.
- DONE: lasts exactly one cycle, done=1, busy=0. Then IDLE. tail_bytes and blk_idx hold their values until the next load.
- last_full and penult are combinational from registered state: BULK && blocks_left==1, qualified by tail_bytes==0 or !=0 respectively.
- Latency:
  - busy rises 1 cycle after an accepted len_load.
  - done rises 1 cycle after the final blk_done.
  - Minimum message length: 1 blk_done.
- Ignored inputs:
  - len_load outside IDLE (no effect, no error).
  - blk_done in IDLE or DONE.
  - A second blk_done in the same cycle is impossible (single-bit pulse).
- abort (any state): next cycle IDLE, busy/last_full/penult/steal_active=0, blocks_left=0, blk_idx=0, tail_bytes=0. No done pulse.
- Priority:
  - abort over blk_done.
  - abort over len_load in the same cycle; the load is dropped.
- Arithmetic:
  - Counters are unsigned CNT_W.
  - blocks_left never underflows: it is decremented only in BULK with a value of at least 1.
  - blk_idx cannot overflow, because blk_idx ≤ full+1 ≤ 2^CNT_W only when the tail is non-zero. Exception: full=all-ones with tail!=0 wraps blk_idx to 0 on the STEAL block. This wrap is accepted and documented; the tweak logic uses blk_idx modulo 2^CNT_W.

Decomposition:
- Package xts_pkg: state enum (IDLE, BULK, STEAL, DONE), default BLOCK_BYTES, and functions deriving OFF_W/CNT_W.
- One natural sub-module: xts_blk_counter, a loadable down counter with terminal-at-one flag, used for blocks_left.
- blk_idx is a plain incrementer in the top module.

Test Plan:
All scenarios use BLOCK_BYTES=16, LEN_W=128.
- len_in=64 → busy next cycle, blocks_left=4, tail_bytes=0. After 3 blk_done, last_full=1 and penult=0. 4th blk_done → done pulse next cycle, steal_active never high, blk_idx=4.
- len_in=37 → blocks_left=2, tail_bytes=5. After 1 blk_done, penult=1. 2nd blk_done → steal_active=1, blocks_left=0. 3rd blk_done → done, blk_idx=3.
- len_in=15 → len_err pulse exactly 1 cycle, busy stays 0. A following len_in=16 is accepted with blocks_left=1 and last_full=1.
- len_in=160, then 3 blk_done, then abort coincident with a 4th blk_done → IDLE next cycle, all outputs 0, no done. A len_load during BULK earlier in the run is ignored.
- n_rst asserted mid-BULK, asynchronously between clock edges → outputs 0 immediately. Operation after release proceeds from IDLE.
- len_in=2^128-1 → blocks_left=2^124-1, tail_bytes=15. Run 3 blk_done → blocks_left=2^124-4, blk_idx=3, no false last_full.
